// File: rtl/serv_bus_arbiter_pkg.sv
// Shared types and constants for the SERV ibus/dbus memory-port arbiter.
package serv_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    IBUS = 1'b0,
    DBUS = 1'b1
  } grant_t;

  // The instruction bus only ever reads full words.
  localparam logic [3:0] IBUS_DEF_SEL = 4'hF;

  // Round-robin pick: on a tie the requester that did not win last time goes next.
  function automatic grant_t rr_pick(input logic ireq, input logic dreq, input grant_t last);
    if (ireq && dreq) begin
      return (last == IBUS) ? DBUS : IBUS;
    end else if (dreq) begin
      return DBUS;
    end
    return IBUS;
  endfunction

endpackage

// File: rtl/serv_bus_watchdog.sv
// Saturating cycle counter that flags when a granted transaction has waited too long.
module serv_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over count; the counter holds at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == TO_VAL);

endmodule

// File: rtl/serv_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style memory port between SERV ibus and dbus,
// with a watchdog that terminates hung transactions with an error ack.
module serv_bus_arbiter
  import serv_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] ibus_adr,
  input  logic        ibus_cyc,
  output logic [31:0] ibus_rdt,
  output logic        ibus_ack,
  input  logic [31:0] dbus_adr,
  input  logic [31:0] dbus_dat,
  input  logic [3:0]  dbus_sel,
  input  logic        dbus_we,
  input  logic        dbus_cyc,
  output logic [31:0] dbus_rdt,
  output logic        dbus_ack,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_dat,
  output logic [3:0]  mem_sel,
  output logic        mem_we,
  output logic        mem_cyc,
  input  logic [31:0] mem_rdt,
  input  logic        mem_ack,
  output logic        timeout_err
);

  arb_state_t state_q;
  arb_state_t state_d;
  grant_t     last_grant_q;
  grant_t     last_grant_d;
  logic       timeout_err_q;
  logic       timeout_err_d;

  logic gnt_i;
  logic gnt_d;
  logic req_cyc;
  logic wdog_expired;
  logic fire_timeout;

  assign gnt_i = (state_q == GNT_I);
  assign gnt_d = (state_q == GNT_D);

  // Granted requester still holding its request.
  assign req_cyc = (gnt_i & ibus_cyc) | (gnt_d & dbus_cyc);

  // A real ack in the expiry cycle is a normal completion, so the timeout needs !mem_ack.
  assign fire_timeout = req_cyc & wdog_expired & ~mem_ack;

  // Counter sits at zero in IDLE, so every grant starts counting from zero.
  serv_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (state_q == IDLE),
    .en      (req_cyc & ~mem_ack),
    .expired (wdog_expired)
  );

  // Next-state: arbitrate in IDLE, return to IDLE on ack, abort or timeout.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (ibus_cyc || dbus_cyc) begin
          last_grant_d = rr_pick(ibus_cyc, dbus_cyc, last_grant_q);
          state_d      = (last_grant_d == DBUS) ? GNT_D : GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (!req_cyc || mem_ack || wdog_expired) begin
          state_d = IDLE;
        end
        if (fire_timeout) begin
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, round-robin history and sticky error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= IBUS;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Port steering: pure selection, everything zero outside a grant.
  always_comb begin
    mem_adr  = '0;
    mem_dat  = '0;
    mem_sel  = '0;
    mem_we   = 1'b0;
    ibus_ack = 1'b0;
    ibus_rdt = '0;
    dbus_ack = 1'b0;
    dbus_rdt = '0;
    if (gnt_i) begin
      mem_adr  = ibus_adr;
      mem_sel  = IBUS_DEF_SEL;
      ibus_ack = (req_cyc & mem_ack) | fire_timeout;
      ibus_rdt = fire_timeout ? 32'h0 : mem_rdt;
    end
    if (gnt_d) begin
      mem_adr  = dbus_adr;
      mem_dat  = dbus_dat;
      mem_sel  = dbus_sel;
      mem_we   = dbus_we;
      dbus_ack = (req_cyc & mem_ack) | fire_timeout;
      dbus_rdt = fire_timeout ? 32'h0 : mem_rdt;
    end
  end

  assign mem_cyc     = req_cyc & ~fire_timeout;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/serv_bus_arbiter.md
Name: serv_bus_arbiter

Overview:
- Shares one Wishbone-style memory port between the SERV instruction bus (ibus) and data bus (dbus).
- Sits between serv_rf_top and a single-port memory or formal memory model.
- Round-robin arbitration; grant held until ack or abort.
- Watchdog terminates hung transactions with an error ack.

Parameters:
- TIMEOUT_CYCLES, 15: cycles a granted transaction may wait for mem_ack before forced termination; legal range 1..255.
- CNT_W, 8: watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ibus_adr  in  32  instruction fetch address.
- ibus_cyc  in  1  instruction request.
- ibus_rdt  out  32  instruction read data.
- ibus_ack  out  1  instruction ack.
- dbus_adr  in  32  data address.
- dbus_dat  in  32  write data.
- dbus_sel  in  4  byte enables.
- dbus_we  in  1  write enable.
- dbus_cyc  in  1  data request.
- dbus_rdt  out  32  data read data.
- dbus_ack  out  1  data ack.
- mem_adr  out  32  shared port address.
- mem_dat  out  32  shared port write data.
- mem_sel  out  4  shared port byte enables.
- mem_we  out  1  shared port write enable.
- mem_cyc  out  1  shared port request.
- mem_rdt  in  32  shared port read data.
- mem_ack  in  1  shared port ack.
- timeout_err  out  1  sticky: a watchdog termination has occurred.

Behaviour:
- Reset: all registers clear asynchronously while reset_n=0.
  - state=IDLE, last_grant=IBUS, wdog=0, timeout_err=0.
  - Every output is 0 during reset and in IDLE.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Only ibus_cyc → GNT_I. Only dbus_cyc → GNT_D.
  - Both asserted → grant the requester not equal to last_grant (first tie after reset goes to dbus).
  - Neither → stay in IDLE.
  - last_grant updates on entry to GNT_x.
- Arbitration latency: mem_cyc first asserts the cycle after the request is seen in IDLE. Minimum request-to-ack latency is 2 cycles with a zero-wait memory.
- GNT_x datapath:
  - mem_cyc = x_cyc (combinational).
  - mem_adr, mem_dat, mem_sel, mem_we come from x. ibus drives mem_dat=0, mem_sel=4'hF, mem_we=0.
  - x_ack = mem_ack, x_rdt = mem_rdt (combinational). The non-granted requester sees ack=0 and rdt=0.
- Completion: mem_ack=1 in GNT_x → IDLE next cycle. There is no back-to-back grant; one IDLE cycle always separates transactions.
- Abort: x_cyc=0 while in GNT_x → mem_cyc drops the same cycle, IDLE next cycle, no ack issued.
- Watchdog:
  - wdog clears on entry to GNT_x and increments each GNT_x cycle without mem_ack.
  - When wdog==TIMEOUT_CYCLES and mem_ack=0, that cycle:
    - x_ack=1 and x_rdt=32'h0;
    - mem_cyc forced 0;
    - timeout_err set (cleared only by reset);
    - next state IDLE.
- mem_ack while mem_cyc=0 (IDLE, abort, or after timeout) is ignored. It must never reach either requester.
- mem_ack and timeout in the same cycle: normal completion wins, and timeout_err is not set.
- Request dropped in IDLE before grant: no grant and no state change.
- Widths: all muxes are pure selection with no arithmetic except wdog. wdog saturates and never wraps.

Decomposition:
- Package serv_bus_arbiter_pkg:
  - arb_state_t enum (IDLE, GNT_I, GNT_D), 2 bits;
  - grant_t enum (IBUS, DBUS);
  - constant IBUS_DEF_SEL=4'hF.
- Sub-module serv_bus_watchdog: holds the CNT_W counter, with clear/enable inputs and a timeout output.
- The FSM and mux logic stay in the top module.

Test Plan:
- Single fetch: ibus_cyc=1, ibus_adr=32'h100, memory acks 1 cycle after mem_cyc with mem_rdt=32'h00000013. Required: mem_adr=32'h100, ibus_ack=1, ibus_rdt=32'h13; dbus_ack=0 throughout; IDLE next cycle.
- Simultaneous requests after reset, both held for 4 transactions with zero-wait memory. Required grant order: DBUS, IBUS, DBUS, IBUS.
- dbus store: dbus_adr=32'h2004, dbus_dat=32'hDEADBEEF, sel=4'b0011, we=1. Required: mem_* mirror these exactly; dbus_ack follows mem_ack; ibus_rdt stays 0.
- Timeout with TIMEOUT_CYCLES=3 and mem_ack never asserted. Required: ibus_ack=1 with rdt=0 on the 4th granted cycle; mem_cyc=0 that cycle; timeout_err=1 and sticky; a late mem_ack is ignored.
- Abort: dbus_cyc drops 2 cycles into the grant. Required: mem_cyc drops the same cycle, no dbus_ack, timeout_err stays 0.
- Reset mid-transaction: reset_n=0 during GNT_D. Required: mem_cyc=0 immediately (asynchronous); after release the first tie goes to DBUS again.
